dmem_arbiter: RTL and testbench

//  Shares the single-port synchronous data RAM between two requesters.
//  - Port 0 is the core load/store path.
//  - Port 1 is the secondary master (debug loader / test DMA).

---
 rtl/dmem_arb_pkg.sv | 11 +
 rtl/arb_pick2.sv | 11 +
 rtl/dmem_arbiter.sv | 85 ++++++++
 tb/tb_dmem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and owner encodings for the data-RAM arbiter
package dmem_arb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_RESP} arb_state_t;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;
    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;
endpackage

// File: rtl/arb_pick2.sv
// arb_pick2: combinational two-way picker, fixed priority or round-robin on ties
module arb_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic       rr_en,
    output logic [1:0] gnt
);
    assign gnt = (&req) ? ((rr_en && last_owner == OWNER_M0) ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port req/gnt arbiter owning the single-port data RAM; DMEM_ARB_RR_EN selects round-robin tie-break
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);
    arb_state_t r_state, w_next;
    mem_cmd_t   r_cmd, w_cmd;
    logic       r_owner;
    logic       w_last_owner, w_rr_en, w_gnt_ok, w_resp;
    logic [1:0] w_req, w_gnt;
`ifdef DMEM_ARB_RR_EN
    logic r_last_owner;
    assign w_rr_en      = 1'b1;
    assign w_last_owner = r_last_owner;
    // remember the most recent winner so the other port takes the next tie
    always_ff @(posedge clk)
        if (rst) r_last_owner <= OWNER_M1;
        else if (|w_gnt) r_last_owner <= w_gnt[1];
`else
    assign w_rr_en      = 1'b0;
    assign w_last_owner = 1'b0;
`endif
    assign w_gnt_ok = !rst && r_state != ARB_ISSUE;
    assign w_req    = {m1_req, m0_req} & {2{w_gnt_ok}};
    assign m0_gnt   = w_gnt[0];
    assign m1_gnt   = w_gnt[1];
    assign w_cmd    = w_gnt[1] ? mem_cmd_t'{we: m1_we, addr: m1_addr, wdata: m1_wdata}
                               : mem_cmd_t'{we: m0_we, addr: m0_addr, wdata: m0_wdata};
    arb_pick2 u_pick (
        .req        (w_req),
        .last_owner (w_last_owner),
        .rr_en      (w_rr_en),
        .gnt        (w_gnt)
    );
    // state register plus the command latched from the winning port
    always_ff @(posedge clk)
        if (rst) begin
            r_state <= ARB_IDLE;
            r_owner <= OWNER_M0;
            r_cmd   <= '0;
        end else begin
            r_state <= w_next;
            if (|w_gnt) begin
                r_owner <= w_gnt[1];
                r_cmd   <= w_cmd;
            end
        end
    // next state, RAM strobe in ISSUE, response to the latched owner in RESP
    always_comb begin
        w_next    = (r_state == ARB_ISSUE) ? ARB_RESP : ((|w_gnt) ? ARB_ISSUE : ARB_IDLE);
        ram_en    = r_state == ARB_ISSUE;
        ram_we    = ram_en && r_cmd.we;
        ram_addr  = ram_en ? r_cmd.addr : '0;
        ram_wdata = ram_en ? r_cmd.wdata : '0;
        w_resp    = r_state == ARB_RESP && !rst;
        m0_rvalid = w_resp && r_owner == OWNER_M0;
        m1_rvalid = w_resp && r_owner == OWNER_M1;
        m0_rdata  = (m0_rvalid && !r_cmd.we) ? ram_rdata : '0;
        m1_rdata  = (m1_rvalid && !r_cmd.we) ? ram_rdata : '0;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table vectors, hand sequences and a response scoreboard for dmem_arbiter
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    int          n_checks = 0, n_errors = 0, cyc = 0;
    logic [31:0] last_rd [2];
    bit          got [2];

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          g;
    } sb_t;
    sb_t sb [$];

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [8];

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // synchronous single-port RAM: read data one cycle after the strobe
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_en) begin
            if (ram_we) mem[ram_addr[7:2]] <= ram_wdata;
            else ram_rdata <= mem[ram_addr[7:2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard: push on grant using the reference memory, check strobe and response later
    always @(negedge clk) begin
        sb_t e;
        bit  issue_due, resp_due;
        issue_due = 0;
        resp_due  = 0;
        if (rst) begin
            chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 0);
            chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 0);
            sb.delete();
        end else begin
            chk("gnt_onehot", {31'd0, m0_gnt & m1_gnt}, 0);
            chk("gnt_without_req", {31'd0, (m0_gnt & !m0_req) | (m1_gnt & !m1_req)}, 0);
            chk("rdata_zero_m0", m0_rvalid ? 32'd0 : m0_rdata, 0);
            chk("rdata_zero_m1", m1_rvalid ? 32'd0 : m1_rdata, 0);
            if (sb.size() > 0) begin
                e = sb[0];
                if (cyc == e.g + 1) begin
                    issue_due = 1;
                    chk("ram_en", {31'd0, ram_en}, 1);
                    chk("ram_we", {31'd0, ram_we}, {31'd0, e.we});
                    chk("ram_addr", ram_addr, e.addr);
                    chk("ram_wdata", ram_wdata, e.wdata);
                end else if (cyc == e.g + 2) begin
                    resp_due = 1;
                    chk("rvalid_port", {30'd0, m1_rvalid, m0_rvalid}, e.port ? 2 : 1);
                    chk("rdata_owner", e.port ? m1_rdata : m0_rdata, e.we ? 32'd0 : e.rdata);
                    chk("rdata_other", e.port ? m0_rdata : m1_rdata, 0);
                    last_rd[e.port] = e.port ? m1_rdata : m0_rdata;
                    got[e.port] = 1;
                    void'(sb.pop_front());
                end
            end
            if (!issue_due) chk("ram_en_quiet", {31'd0, ram_en}, 0);
            if (!resp_due) chk("rvalid_quiet", {30'd0, m1_rvalid, m0_rvalid}, 0);
            if (m0_gnt || m1_gnt) begin
                e.port  = m1_gnt;
                e.we    = m1_gnt ? m1_we : m0_we;
                e.addr  = m1_gnt ? m1_addr : m0_addr;
                e.wdata = m1_gnt ? m1_wdata : m0_wdata;
                e.g     = cyc;
                e.rdata = e.we ? 32'd0 : ref_mem[e.addr[7:2]];
                if (e.we) ref_mem[e.addr[7:2]] = e.wdata;
                sb.push_back(e);
            end
        end
    end

    task automatic set_port(input bit p, input bit req, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata);
        if (p) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic wait_gnt(input bit p, output bit ok);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (p ? m1_gnt : m0_gnt) begin
                ok = 1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_txn(input vec_t v, input string name);
        bit ok;
        got[v.port] = 0;
        set_port(v.port, 1, v.we, v.addr, v.wdata);
        wait_gnt(v.port, ok);
        chk({name, "_gnt"}, {31'd0, ok}, 1);
        @(posedge clk);
        #1;
        set_port(v.port, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_rvalid_seen"}, {31'd0, got[v.port]}, {31'd0, ok});
        chk({name, "_rdata"}, last_rd[v.port], ok ? v.exp : last_rd[v.port]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        for (int i = 0; i < 64; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        mem[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        vecs[0] = '{0, 0, 32'h10, 32'h0, 32'hDEADBEEF};
        vecs[1] = '{1, 1, 32'h20, 32'h12345678, 32'h0};
        vecs[2] = '{0, 0, 32'h20, 32'h0, 32'h12345678};
        vecs[3] = '{0, 1, 32'h30, 32'hA5A50001, 32'h0};
        vecs[4] = '{1, 0, 32'h30, 32'h0, 32'hA5A50001};
        vecs[5] = '{1, 1, 32'h10, 32'hCAFEF00D, 32'h0};
        vecs[6] = '{0, 0, 32'h10, 32'h0, 32'hCAFEF00D};
        vecs[7] = '{1, 0, 32'h3C, 32'h0, 32'h0};

        // reset held with both ports requesting
        set_port(0, 1, 0, 32'h0, 32'h0);
        set_port(1, 1, 0, 32'h4, 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_ram_en", {31'd0, ram_en}, 0);
            chk("rst_m0_gnt", {31'd0, m0_gnt}, 0);
        end
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_m0_gnt", {31'd0, m0_gnt}, 1);
        chk("post_rst_m1_gnt", {31'd0, m1_gnt}, 0);
        @(posedge clk);
        #1;
        set_port(0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // write on m1 followed immediately by a read on m0 granted in RESP
        set_port(1, 1, 1, 32'h24, 32'h0BADF00D);
        wait_gnt(1, ok);
        chk("b2b_wr_gnt", {31'd0, ok}, 1);
        @(posedge clk);
        #1;
        set_port(1, 0, 0, 0, 0);
        set_port(0, 1, 0, 32'h24, 32'h0);
        @(negedge clk);
        chk("b2b_no_gnt_in_issue", {31'd0, m0_gnt}, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b2b_rd_gnt_in_resp", {31'd0, m0_gnt}, 1);
        chk("b2b_wr_rvalid", {31'd0, m1_rvalid}, 1);
        @(posedge clk);
        #1;
        set_port(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b2b_rd_rvalid", {31'd0, m0_rvalid}, 1);
        chk("b2b_rd_rdata", m0_rdata, 32'h0BADF00D);
        @(posedge clk);
        #1;

        // tie with both requests held from a fresh reset
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        set_port(0, 1, 0, 32'h10, 32'h0);
        set_port(1, 1, 0, 32'h20, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
`ifdef DMEM_ARB_RR_EN
            chk($sformatf("tie_rr_m0_gnt%0d", i), {31'd0, m0_gnt}, (i % 4 == 0) ? 1 : 0);
            chk($sformatf("tie_rr_m1_gnt%0d", i), {31'd0, m1_gnt}, (i % 4 == 2) ? 1 : 0);
`else
            chk($sformatf("tie_fp_m0_gnt%0d", i), {31'd0, m0_gnt}, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("tie_fp_m1_gnt%0d", i), {31'd0, m1_gnt}, 0);
`endif
            @(posedge clk);
            #1;
        end
        set_port(0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        // reset during ISSUE aborts the read; m1 is granted right after
        set_port(0, 1, 0, 32'h10, 32'h0);
        wait_gnt(0, ok);
        chk("midrst_gnt", {31'd0, ok}, 1);
        @(posedge clk);
        #1;
        rst = 1;
        set_port(0, 0, 0, 0, 0);
        set_port(1, 1, 0, 32'h20, 32'h0);
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("midrst_no_rvalid", {31'd0, m0_rvalid}, 0);
        chk("midrst_m1_gnt", {31'd0, m1_gnt}, 1);
        @(posedge clk);
        #1;
        set_port(1, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
